mc_ctrl_fsm: RTL and testbench

MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

---
 rtl/mc_ctrl_fsm.sv | 210 +++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// Multicycle control FSM: fetch, timed decode, dispatch on op/funct, a memory
// handshake with a timeout, and one-cycle illegal-op / bus-error pulses.
module mc_ctrl_fsm #(
    parameter int DEC_WAIT    = 2,
    parameter int MEM_TIMEOUT = 8,
    parameter int LINK_REG    = 31
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       mem_ack,
    input  logic       stall,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_req,
    output logic       mem_write,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       branch,
    output logic       jump,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] reg_dst,
    output logic       link,
    output logic       illegal_op,
    output logic       bus_err,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'h0,
        S_DECODE = 4'h1,
        S_MEMADR = 4'h2,
        S_MEMRD  = 4'h3,
        S_MEMWB  = 4'h4,
        S_MEMWR  = 4'h5,
        S_EXEC   = 4'h6,
        S_ALUWB  = 4'h7,
        S_BRANCH = 4'h8,
        S_IEXEC  = 4'h9,
        S_IWB    = 4'hA,
        S_JUMP   = 4'hB,
        S_LINKWB = 4'hC,
        S_EXC    = 4'hD
    } state_t;

    localparam logic [3:0] DEC_LAST = 4'(DEC_WAIT - 1);
    localparam logic [7:0] MEM_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state_q;
    state_t     next_state;
    logic [3:0] dec_cnt;
    logic [7:0] mem_cnt;
    logic       is_load;
    logic       is_sub_store;
    logic       is_store;
    logic       is_mem;

    // LINK_REG is applied by the datapath's destination mux when reg_dst == 2.
    logic unused_link;
    assign unused_link = (LINK_REG == 0);

    assign state = state_q;

    always_comb begin
        is_load      = op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
        is_sub_store = op inside {6'h28, 6'h29};
        is_store     = is_sub_store || (op == 6'h2B);
        is_mem       = is_load || is_store;
    end

    // NOTE: every output and next_state gets a default first so no path infers a latch.
    always_comb begin
        next_state = state_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        reg_dst    = 2'd0;
        link       = 1'b0;
        illegal_op = 1'b0;
        bus_err    = 1'b0;

        case (state_q)
            S_FETCH: begin
                pc_write   = 1'b1;
                alu_src_b  = 2'd1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                ir_write  = 1'b1;
                alu_src_b = 2'd3;
                if (dec_cnt == DEC_LAST) begin
                    if (op == 6'h00) begin
                        if (funct == 6'h08)      next_state = S_JUMP;
                        else if (funct == 6'h09) next_state = S_LINKWB;
                        else                     next_state = S_EXEC;
                    end
                    else if (op inside {[6'h08:6'h0F]})        next_state = S_IEXEC;
                    else if (is_mem)                           next_state = S_MEMADR;
                    else if (op inside {6'h01, [6'h04:6'h07]}) next_state = S_BRANCH;
                    else if (op == 6'h02)                      next_state = S_JUMP;
                    else if (op == 6'h03)                      next_state = S_LINKWB;
                    else                                       next_state = S_EXC;
                end
            end
            S_MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'd2;
                // Sub-word stores read the word first so they can merge the new bytes.
                next_state = (is_store && !is_sub_store) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                if (mem_ack)                  next_state = is_sub_store ? S_MEMWR : S_MEMWB;
                else if (mem_cnt == MEM_LAST) next_state = S_EXC;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                if (mem_ack)                  next_state = S_FETCH;
                else if (mem_cnt == MEM_LAST) next_state = S_EXC;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                next_state = S_FETCH;
            end
            S_EXEC: begin
                alu_src_a  = 1'b1;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = 2'd1;
                next_state = S_FETCH;
            end
            S_IEXEC: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'd2;
                next_state = S_IWB;
            end
            S_IWB: begin
                reg_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                branch     = 1'b1;
                pc_write   = 1'b1;
                next_state = S_FETCH;
            end
            S_JUMP: begin
                jump       = 1'b1;
                pc_write   = 1'b1;
                next_state = S_FETCH;
            end
            S_LINKWB: begin
                reg_write  = 1'b1;
                link       = 1'b1;
                reg_dst    = (op == 6'h03) ? 2'd2 : 2'd1;
                next_state = S_JUMP;
            end
            S_EXC: begin
                // The held opcode tells the two entry paths apart: only memory ops time out.
                illegal_op = !is_mem;
                bus_err    = is_mem;
                next_state = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase

        // A stalled cycle repeats next time, so nothing may commit and pulses wait for it.
        if (stall) begin
            next_state = state_q;
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            illegal_op = 1'b0;
            bus_err    = 1'b0;
        end
    end

    // NOTE: state and counters use non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            dec_cnt <= '0;
            mem_cnt <= '0;
        end else if (!stall) begin
            state_q <= next_state;
            if (next_state != state_q) begin
                dec_cnt <= '0;
                mem_cnt <= '0;
            end else begin
                if (state_q == S_DECODE) dec_cnt <= dec_cnt + 4'd1;
                if (state_q == S_MEMRD || state_q == S_MEMWR) mem_cnt <= mem_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: an instruction-level model expands each
// instruction into its expected cycle trace; a negedge monitor compares every cycle.
module tb_mc_ctrl_fsm;

    localparam int DEC_WAIT    = 2;
    localparam int MEM_TIMEOUT = 8;
    localparam int LINK_REG    = 31;

    localparam logic [3:0] S_FETCH  = 4'h0;
    localparam logic [3:0] S_DECODE = 4'h1;
    localparam logic [3:0] S_MEMADR = 4'h2;
    localparam logic [3:0] S_MEMRD  = 4'h3;
    localparam logic [3:0] S_MEMWB  = 4'h4;
    localparam logic [3:0] S_MEMWR  = 4'h5;
    localparam logic [3:0] S_EXEC   = 4'h6;
    localparam logic [3:0] S_ALUWB  = 4'h7;
    localparam logic [3:0] S_BRANCH = 4'h8;
    localparam logic [3:0] S_IEXEC  = 4'h9;
    localparam logic [3:0] S_IWB    = 4'hA;
    localparam logic [3:0] S_JUMP   = 4'hB;
    localparam logic [3:0] S_LINKWB = 4'hC;
    localparam logic [3:0] S_EXC    = 4'hD;

    typedef enum {C_RALU, C_JR, C_JALR, C_IALU, C_LOAD, C_SW, C_SUBST,
                  C_BR, C_J, C_JAL, C_ILL} cls_e;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_write;
        logic       ir_write;
        logic       mem_req;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       branch;
        logic       jump;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] reg_dst;
        logic       link;
        logic       illegal_op;
        logic       bus_err;
    } outs_t;

    typedef struct {
        outs_t o;
        string name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       mem_ack;
    logic       stall;
    logic       pc_write, ir_write, mem_req, mem_write, reg_write, mem_to_reg;
    logic       branch, jump, alu_src_a, link, illegal_op, bus_err;
    logic [1:0] alu_src_b, reg_dst;
    logic [3:0] state;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         stall_pct = 0;
    int         forced_ack = -1;
    int         instr_idx = 0;
    logic [5:0] cur_op = '0;
    logic [5:0] cur_funct = '0;
    cls_e       cur_cls = C_RALU;
    logic [5:0] op_pool [0:20] = '{6'h00, 6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04,
                                   6'h05, 6'h06, 6'h07, 6'h08, 6'h0A, 6'h0F, 6'h20,
                                   6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};

    mc_ctrl_fsm #(
        .DEC_WAIT(DEC_WAIT),
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .LINK_REG(LINK_REG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .mem_ack(mem_ack), .stall(stall),
        .pc_write(pc_write), .ir_write(ir_write), .mem_req(mem_req), .mem_write(mem_write),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .branch(branch), .jump(jump),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_dst(reg_dst), .link(link),
        .illegal_op(illegal_op), .bus_err(bus_err), .state(state)
    );

    always #5 clk = ~clk;

    function automatic cls_e classify(input logic [5:0] o, input logic [5:0] f);
        if (o == 6'h00) begin
            if (f == 6'h08) return C_JR;
            if (f == 6'h09) return C_JALR;
            return C_RALU;
        end
        if (o inside {[6'h08:6'h0F]})                        return C_IALU;
        if (o inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25})    return C_LOAD;
        if (o == 6'h2B)                                      return C_SW;
        if (o inside {6'h28, 6'h29})                         return C_SUBST;
        if (o inside {6'h01, [6'h04:6'h07]})                 return C_BR;
        if (o == 6'h02)                                      return C_J;
        if (o == 6'h03)                                      return C_JAL;
        return C_ILL;
    endfunction

    // Expected outputs of one cycle, straight from the per-state strobe table.
    function automatic outs_t model_out(input logic [3:0] st, input bit stl);
        outs_t o;
        o = '0;
        o.st = st;
        case (st)
            S_FETCH:  begin o.pc_write = 1'b1; o.alu_src_b = 2'd1; end
            S_DECODE: begin o.ir_write = 1'b1; o.alu_src_b = 2'd3; end
            S_MEMADR: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; end
            S_MEMRD:  o.mem_req = 1'b1;
            S_MEMWR:  begin o.mem_req = 1'b1; o.mem_write = 1'b1; end
            S_MEMWB:  begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; end
            S_EXEC:   o.alu_src_a = 1'b1;
            S_ALUWB:  begin o.reg_write = 1'b1; o.reg_dst = 2'd1; end
            S_IEXEC:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; end
            S_IWB:    o.reg_write = 1'b1;
            S_BRANCH: begin o.alu_src_a = 1'b1; o.branch = 1'b1; o.pc_write = 1'b1; end
            S_JUMP:   begin o.jump = 1'b1; o.pc_write = 1'b1; end
            S_LINKWB: begin
                o.reg_write = 1'b1;
                o.link      = 1'b1;
                o.reg_dst   = (cur_cls == C_JAL) ? 2'd2 : 2'd1;
            end
            S_EXC: begin
                o.illegal_op = (cur_cls == C_ILL);
                o.bus_err    = cur_cls inside {C_LOAD, C_SW, C_SUBST};
            end
            default: ;
        endcase
        if (stl) begin
            o.pc_write   = 1'b0;
            o.ir_write   = 1'b0;
            o.mem_write  = 1'b0;
            o.reg_write  = 1'b0;
            o.illegal_op = 1'b0;
            o.bus_err    = 1'b0;
        end
        return o;
    endfunction

    task automatic drive_cycle(input logic [3:0] st, input bit stl, input bit ack);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        op      = cur_op;
        funct   = cur_funct;
        stall   = stl;
        mem_ack = ack;
        e.o     = model_out(st, stl);
        e.name  = $sformatf("instr%0d op%02h state%0h stall%0b", instr_idx, cur_op, st, stl);
        exp_q.push_back(e);
    endtask

    task automatic reset_cycles(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rst_n   = 1'b0;
            stall   = 1'b0;
            mem_ack = 1'b0;
            e.o     = model_out(S_FETCH, 1'b0);
            e.name  = $sformatf("reset%0d after instr%0d", i, instr_idx);
            exp_q.push_back(e);
        end
    endtask

    // One logical step, optionally preceded by stalled repeats carrying ignored acks.
    task automatic step(input logic [3:0] st, input bit ack);
        int n;
        n = (int'($urandom_range(0, 99)) < stall_pct) ? int'($urandom_range(1, 3)) : 0;
        for (int i = 0; i < n; i++) drive_cycle(st, 1'b1, 1'($urandom_range(0, 1)));
        drive_cycle(st, 1'b0, ack);
    endtask

    function automatic int pick_ack();
        return (forced_ack >= 0) ? forced_ack : int'($urandom_range(1, MEM_TIMEOUT + 3));
    endfunction

    // ack_at counts unstalled wait cycles from 1; outside 1..MEM_TIMEOUT it never lands.
    task automatic mem_wait(input logic [3:0] st, input int ack_at, output bit ok);
        ok = 1'b0;
        for (int k = 1; k <= MEM_TIMEOUT; k++) begin
            step(st, k == ack_at);
            if (k == ack_at) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f);
        bit ok;
        instr_idx++;
        cur_op    = o;
        cur_funct = f;
        cur_cls   = classify(o, f);
        step(S_FETCH, 1'b0);
        for (int i = 0; i < DEC_WAIT; i++) step(S_DECODE, 1'b0);
        case (cur_cls)
            C_RALU:       begin step(S_EXEC, 1'b0); step(S_ALUWB, 1'b0); end
            C_JR, C_J:    step(S_JUMP, 1'b0);
            C_JALR, C_JAL: begin step(S_LINKWB, 1'b0); step(S_JUMP, 1'b0); end
            C_IALU:       begin step(S_IEXEC, 1'b0); step(S_IWB, 1'b0); end
            C_BR:         step(S_BRANCH, 1'b0);
            C_LOAD: begin
                step(S_MEMADR, 1'b0);
                mem_wait(S_MEMRD, pick_ack(), ok);
                step(ok ? S_MEMWB : S_EXC, 1'b0);
            end
            C_SW: begin
                step(S_MEMADR, 1'b0);
                mem_wait(S_MEMWR, pick_ack(), ok);
                if (!ok) step(S_EXC, 1'b0);
            end
            C_SUBST: begin
                step(S_MEMADR, 1'b0);
                mem_wait(S_MEMRD, pick_ack(), ok);
                if (ok) mem_wait(S_MEMWR, pick_ack(), ok);
                if (!ok) step(S_EXC, 1'b0);
            end
            default:      step(S_EXC, 1'b0);
        endcase
    endtask

    // A load frozen by a 5-cycle stall in MEMRD, then reset dropped mid-MEMRD.
    task automatic stall_then_reset();
        instr_idx++;
        cur_op    = 6'h23;
        cur_funct = 6'h00;
        cur_cls   = classify(cur_op, cur_funct);
        drive_cycle(S_FETCH, 1'b0, 1'b0);
        for (int i = 0; i < DEC_WAIT; i++) drive_cycle(S_DECODE, 1'b0, 1'b0);
        drive_cycle(S_MEMADR, 1'b0, 1'b0);
        drive_cycle(S_MEMRD, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive_cycle(S_MEMRD, 1'b1, 1'(i % 2));
        reset_cycles(2);
    endtask

    outs_t act;
    exp_t  cur;
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            act = '{st: state, pc_write: pc_write, ir_write: ir_write, mem_req: mem_req,
                    mem_write: mem_write, reg_write: reg_write, mem_to_reg: mem_to_reg,
                    branch: branch, jump: jump, alu_src_a: alu_src_a, alu_src_b: alu_src_b,
                    reg_dst: reg_dst, link: link, illegal_op: illegal_op, bus_err: bus_err};
            checks++;
            if (act !== cur.o) begin
                errors++;
                $display("FAIL %s: got %05h expected %05h", cur.name, act, cur.o);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] o;
        logic [5:0] f;
        int         r;
        rst_n   = 1'b0;
        stall   = 1'b0;
        mem_ack = 1'b0;
        op      = '0;
        funct   = '0;
        reset_cycles(2);

        run_instr(6'h00, 6'h20);
        forced_ack = 3;
        run_instr(6'h23, 6'h00);
        forced_ack = 0;
        run_instr(6'h2B, 6'h00);
        forced_ack = MEM_TIMEOUT;
        run_instr(6'h23, 6'h00);
        run_instr(6'h28, 6'h00);
        forced_ack = -1;
        run_instr(6'h03, 6'h00);
        run_instr(6'h3F, 6'h00);
        run_instr(6'h00, 6'h09);
        run_instr(6'h00, 6'h08);
        run_instr(6'h0C, 6'h11);
        run_instr(6'h04, 6'h00);
        stall_then_reset();

        stall_pct = 25;
        repeat (150) begin
            r = int'($urandom_range(0, 7));
            o = (r == 0) ? 6'($urandom_range(0, 63)) : op_pool[$urandom_range(0, 20)];
            r = int'($urandom_range(0, 3));
            f = (r == 0) ? 6'h08 : (r == 1) ? 6'h09 : 6'($urandom_range(0, 63));
            run_instr(o, f);
        end
        stall_pct = 0;
        run_instr(6'h02, 6'h00);

        @(posedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
